pwm_decoder: RTL and testbench
==============================

# pwm_decoder

Measures an incoming single-wire PWM signal and recovers its 8-bit duty value on the same 0–255 scale our PWM generator consumes, i.e. duty = round(high_time × 255 / period). Sits at a board input pin (e.g. servo/RC receiver or loop-back from a PWM output) and feeds recovered duty codes to downstream control logic. Period is measured rising-edge to rising-edge, so the decoder tracks frequency drift; a constant-level input is reported through a timeout path.

## Interface
- CLOCK_FREQUENCY, 100000000: system clock in Hz.
- PWM_FREQUENCY, 1000: nominal input PWM frequency in Hz; sets timeout only.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  asynchronous PWM input.
- duty  output  8  last recovered duty code.
- valid  output  1  one-cycle pulse when duty is updated.
- stuck  output  1  high while input has shown no rising edge within the timeout.
- busy  output  1  high while the divider runs.

## Operation
- pwm_in passes a 2-flop synchronizer; edges detected on the synchronized signal (s_pwm) against its previous value.
- Counters: period_cnt and high_cnt, 32-bit, saturating at 2^32−1. period_cnt increments every cycle; high_cnt increments while s_pwm = 1.
- States: IDLE, MEASURE, DIVIDE.
- IDLE: counters held at 0. On rising edge -> MEASURE, counters restart at 1 (that cycle counts), no output.
- MEASURE: on rising edge, latch H = high_cnt, P = period_cnt, restart counters at 1 -> DIVIDE. If period_cnt reaches TIMEOUT = 2 × CLOCK_FREQUENCY / PWM_FREQUENCY -> IDLE with timeout event.
- DIVIDE: unsigned restoring divider, 40-bit numerator N = H × 255 + (P >> 1), 32-bit divisor P, one quotient bit per cycle, 40 cycles. Result saturated to 255 if > 255, written to duty. Counters keep running; returns to MEASURE. Timeout also checked in DIVIDE (applies after divide completes).
- Rising edge during DIVIDE: sample dropped, counters restart at 1, divide continues. Input periods < 42 cycles are therefore unsupported.
- Timeout event: duty <= 255 if s_pwm = 1 else 0; valid pulses; stuck <= 1. stuck clears on the next rising edge. Only one timeout event per stuck interval.
- busy = 1 exactly in DIVIDE.

## Timing
- Reset values: duty = 0, valid = 0, stuck = 0, busy = 0, state IDLE, counters 0, synchronizer flops 0.
- Pin-to-edge latency: 2 cycles synchronizer + 1 cycle edge detect.
- Edge-detect cycle E (latch): DIVIDE occupies E+1 … E+40; duty updated and valid = 1 at E+41 only.
- Timeout: duty/valid/stuck update one cycle after period_cnt = TIMEOUT.
- First period after IDLE or reset produces no output; first valid at the second rising edge + 41 cycles.
- rst_n asserted mid-divide: immediately aborts, all outputs to reset values; no valid emitted.
- P = 0 impossible (counters restart at 1).

## Configuration
- PWM_DECODER_GLITCH_FILTER_EN defined: a 3-cycle majority/stability filter follows the synchronizer; s_pwm changes only after the synchronized input holds a new level for 3 consecutive cycles. Adds 3 cycles of pin-to-edge latency; pulses < 3 cycles are ignored. High and period measurements are unaffected on clean inputs (both edges delayed equally).
- Undefined: no filter; s_pwm is the synchronizer output.

## Test plan
- CLOCK_FREQUENCY=1000, PWM_FREQUENCY=10 (period 100, TIMEOUT 200); pwm_in high 25/low 75 repeating -> after second rising edge, duty = 64, valid single-cycle pulse at E+41, busy high 40 cycles.
- Same setup, high 99/low 1 -> duty = 252; high 1/low 99 -> duty = 3; stuck stays 0.
- Hold pwm_in low 200+ cycles after lock -> duty = 0, valid one pulse, stuck = 1; next rising edge clears stuck, no duty update until following edge + 41.
- Hold pwm_in high 200+ cycles -> duty = 255, stuck = 1, single valid pulse.
- Assert rst_n low during DIVIDE -> duty = 0, valid/busy/stuck = 0 immediately; no pulse after release until two new rising edges.
- With PWM_DECODER_GLITCH_FILTER_EN: insert 2-cycle low glitches into 25/75 waveform -> duty still 64; without the macro, same stimulus produces invalid/dropped samples (no duty = 64 guarantee).

Source files
------------

// File: rtl/pwm_decoder.sv
// pwm_decoder
// ---------------------------------------------------------------------------
// Measures a single-wire PWM input and recovers its duty on the 0..255 scale
// used by the PWM generator:  duty = round(high_time * 255 / period).
// The period is measured from one rising edge to the next, so the decoder
// follows frequency drift. An input that stops toggling is reported through
// a timeout path (duty forced to 0/255 and 'stuck' raised).
//
// Parameters
//   CLOCK_FREQUENCY  system clock in Hz
//   PWM_FREQUENCY    nominal input PWM frequency in Hz (sets the timeout only)
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   pwm_in  in   asynchronous PWM input pin
//   duty    out  [7:0] last recovered duty code
//   valid   out  one-cycle pulse when duty is updated
//   stuck   out  high while no rising edge has been seen within the timeout
//   busy    out  high while the divider runs
//
// Build option
//   PWM_DECODER_GLITCH_FILTER_EN  when defined, a 3-cycle stability filter
//   follows the synchronizer so pulses shorter than 3 cycles are ignored.
// ---------------------------------------------------------------------------
module pwm_decoder #(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned PWM_FREQUENCY   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwm_in,
  output logic [7:0] duty,
  output logic       valid,
  output logic       stuck,
  output logic       busy
);

  // Two nominal periods without a rising edge count as a stuck input.
  localparam logic [31:0] TIMEOUT =
    32'((64'(CLOCK_FREQUENCY) * 64'd2) / 64'(PWM_FREQUENCY));

  // Numerator is 40 bits, one quotient bit is produced per cycle.
  localparam logic [5:0] DIV_LAST_BIT = 6'd39;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } state_t;

  state_t state;
  state_t state_next;

  logic sync_ff1;
  logic sync_ff2;
  logic s_pwm;
  logic s_pwm_d;
  logic rise;

  logic [31:0] period_cnt;
  logic [31:0] high_cnt;

  logic [39:0] div_num;
  logic [31:0] div_den;
  logic [31:0] div_rem;
  logic [5:0]  bit_cnt;

  logic        latch_sample;
  logic        timeout_evt;
  logic        div_done;

  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [39:0] num_next;
  logic [7:0]  div_duty;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // N = H*255 + P/2 ; the P/2 term turns the truncating divide into rounding.
  function automatic logic [39:0] numerator(input logic [31:0] h,
                                            input logic [31:0] p);
    logic [39:0] h_ext;
    h_ext = {8'd0, h};
    return (h_ext << 8) - h_ext + {9'd0, p[31:1]};
  endfunction

  // Input synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= 1'b0;
      sync_ff2 <= 1'b0;
    end else begin
      sync_ff1 <= pwm_in;
      sync_ff2 <= sync_ff1;
    end
  end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic [1:0] filt_cnt;
  logic       filt_q;

  // The filtered level follows the synchronizer only after it has shown the
  // new level for three consecutive cycles; any return to the old level
  // restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= 2'd0;
      filt_q   <= 1'b0;
    end else if (sync_ff2 == filt_q) begin
      filt_cnt <= 2'd0;
    end else if (filt_cnt == 2'd2) begin
      filt_cnt <= 2'd0;
      filt_q   <= sync_ff2;
    end else begin
      filt_cnt <= filt_cnt + 2'd1;
    end
  end

  assign s_pwm = filt_q;
`else
  assign s_pwm = sync_ff2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_pwm_d <= 1'b0;
    end else begin
      s_pwm_d <= s_pwm;
    end
  end

  assign rise = s_pwm & ~s_pwm_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and control strobes. A rising edge during DIVIDE is not a
  // state event: the sample is dropped and only the counters restart.
  // Timeout is only evaluated in MEASURE, so a timeout that expires while
  // dividing takes effect right after the divide completes.
  always_comb begin
    state_next   = state;
    latch_sample = 1'b0;
    timeout_evt  = 1'b0;
    div_done     = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          latch_sample = 1'b1;
          state_next   = DIVIDE;
        end else if (period_cnt >= TIMEOUT) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end
      end
      DIVIDE: begin
        if (bit_cnt == DIV_LAST_BIT) begin
          div_done   = 1'b1;
          state_next = MEASURE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Period and high-time counters. The edge cycle itself counts, hence the
  // restart value of 1 (s_pwm is high on a rising-edge cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt <= 32'd0;
      high_cnt   <= 32'd0;
    end else if (rise) begin
      period_cnt <= 32'd1;
      high_cnt   <= 32'd1;
    end else if (state == IDLE || timeout_evt) begin
      period_cnt <= 32'd0;
      high_cnt   <= 32'd0;
    end else begin
      period_cnt <= sat_inc(period_cnt);
      if (s_pwm) begin
        high_cnt <= sat_inc(high_cnt);
      end
    end
  end

  // One restoring-division step. The remainder stays below the divisor, so
  // 32 bits hold it; the shifted value needs one extra bit for the compare.
  always_comb begin
    rem_shift = {div_rem, div_num[39]};
    rem_diff  = rem_shift - {1'b0, div_den};
    q_bit     = (rem_shift >= {1'b0, div_den});
    rem_next  = q_bit ? rem_diff[31:0] : rem_shift[31:0];
    num_next  = {div_num[38:0], q_bit};
    div_duty  = (|num_next[39:8]) ? 8'hFF : num_next[7:0];
  end

  // Divider registers: the numerator register shifts out dividend bits and
  // shifts in quotient bits, ending up holding the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_num <= 40'd0;
      div_den <= 32'd0;
      div_rem <= 32'd0;
      bit_cnt <= 6'd0;
    end else if (latch_sample) begin
      div_num <= numerator(high_cnt, period_cnt);
      div_den <= period_cnt;
      div_rem <= 32'd0;
      bit_cnt <= 6'd0;
    end else if (state == DIVIDE) begin
      div_num <= num_next;
      div_rem <= rem_next;
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // Output registers. A timeout reports the level the input is stuck at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty  <= 8'd0;
      valid <= 1'b0;
      stuck <= 1'b0;
    end else begin
      valid <= div_done | timeout_evt;
      if (div_done) begin
        duty <= div_duty;
      end else if (timeout_evt) begin
        duty <= s_pwm ? 8'hFF : 8'h00;
      end
      if (timeout_evt) begin
        stuck <= 1'b1;
      end else if (rise) begin
        stuck <= 1'b0;
      end
    end
  end

  assign busy = (state == DIVIDE);

endmodule

// File: tb/tb_pwm_decoder.sv
// tb_pwm_decoder
// ---------------------------------------------------------------------------
// Self-checking bench for pwm_decoder with CLOCK_FREQUENCY=1000 and
// PWM_FREQUENCY=10 (nominal period 100 cycles, timeout 200 cycles).
// A cycle-level behavioural model derives duty/valid/stuck/busy from the
// pin waveform using the rounding formula directly; a compare process checks
// every cycle, and directed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_pwm_decoder;

  localparam int TIMEOUT = 2 * 1000 / 10;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       pwm_in;
  logic [7:0] duty;
  logic       valid;
  logic       stuck;
  logic       busy;

  // Level the model measures; differs from pwm_in only inside glitches.
  logic       ideal_pwm;

  int checks = 0;
  int errors = 0;

  pwm_decoder #(
    .CLOCK_FREQUENCY(1000),
    .PWM_FREQUENCY  (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .duty  (duty),
    .valid (valid),
    .stuck (stuck),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state.
  int         cyc = 0;
  logic       m_hist [0:4];
  logic       m_prev_s;
  logic       m_armed;
  int         m_last_rise;
  int         m_hcount;
  int         m_div_last;
  logic [7:0] m_result;
  logic [7:0] exp_duty;
  logic       exp_valid;
  logic       exp_stuck;
  logic       exp_busy;

  // Observations used by the literal checks.
  int valid_count   = 0;
  int busy_run      = 0;
  int last_busy_run = 0;
  int double_valid  = 0;
  logic prev_valid  = 1'b0;

  function automatic logic [7:0] expectedDuty(input int h, input int p);
    longint n;
    longint q;
    n = longint'(h) * 255 + longint'(p) / 2;
    q = n / longint'(p);
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  // Compare process: checks the DUT against the model, then advances the
  // model by the events of this cycle.
  always @(negedge clk) begin
    logic       s;
    logic       rise;
    logic       in_div;
    logic [7:0] n_duty;
    logic       n_valid;
    logic       n_stuck;
    logic       n_busy;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) m_hist[i] = 1'b0;
      m_prev_s   = 1'b0;
      m_armed    = 1'b0;
      m_hcount   = 0;
      m_div_last = -1;
      exp_duty   = 8'd0;
      exp_valid  = 1'b0;
      exp_stuck  = 1'b0;
      exp_busy   = 1'b0;
    end
    checks++;
    if ({duty, valid, stuck, busy} !== {exp_duty, exp_valid, exp_stuck, exp_busy}) begin
      errors++;
      $display("[TB] FAIL cycle %0d: dut duty=%0d valid=%0b stuck=%0b busy=%0b, model duty=%0d valid=%0b stuck=%0b busy=%0b",
               cyc, duty, valid, stuck, busy, exp_duty, exp_valid, exp_stuck, exp_busy);
    end
    if (rst_n) begin
      s = m_hist[LAT-1];
      for (int i = 4; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ideal_pwm;
      rise    = s && !m_prev_s;
      in_div  = exp_busy;
      n_duty  = exp_duty;
      n_valid = 1'b0;
      n_stuck = exp_stuck;
      n_busy  = in_div;
      if (in_div && cyc == m_div_last) begin
        n_duty  = m_result;
        n_valid = 1'b1;
        n_busy  = 1'b0;
      end
      if (rise) begin
        n_stuck = 1'b0;
        if (m_armed && !in_div) begin
          m_result   = expectedDuty(m_hcount, cyc - m_last_rise);
          m_div_last = cyc + 40;
          n_busy     = 1'b1;
        end
        m_armed     = 1'b1;
        m_last_rise = cyc;
        m_hcount    = 1;
      end else begin
        if (m_armed && !in_div && (cyc - m_last_rise) >= TIMEOUT) begin
          n_duty  = s ? 8'd255 : 8'd0;
          n_valid = 1'b1;
          n_stuck = 1'b1;
          m_armed = 1'b0;
        end
        m_hcount += int'(s);
      end
      m_prev_s  = s;
      exp_duty  = n_duty;
      exp_valid = n_valid;
      exp_stuck = n_stuck;
      exp_busy  = n_busy;
    end
    if (valid) valid_count++;
    if (valid && prev_valid) double_valid++;
    prev_valid = valid;
    if (busy) begin
      busy_run++;
    end else begin
      if (busy_run > 0) last_busy_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveCycle(input logic ideal, input logic pin);
    @(posedge clk);
    #2;
    ideal_pwm = ideal;
    pwm_in    = pin;
  endtask

  // Drives 'reps' periods of high/low; glitch_at >= 0 pulls the pin low for
  // two cycles at that offset into each high phase.
  task automatic applyStimulus(input int high_cycles, input int low_cycles,
                               input int reps, input int glitch_at = -1);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < high_cycles; i++) begin
        driveCycle(1'b1, (glitch_at >= 0 && (i == glitch_at || i == glitch_at + 1)) ? 1'b0 : 1'b1);
      end
      for (int i = 0; i < low_cycles; i++) begin
        driveCycle(1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    int mark;
    rst_n     = 1'b0;
    pwm_in    = 1'b0;
    ideal_pwm = 1'b0;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_duty", int'(duty), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_stuck", int'(stuck), 0);
    checkOutput("reset_busy", int'(busy), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 25/75: round(25*255/100) = 64
    mark = valid_count;
    applyStimulus(25, 75, 4);
    checkOutput("duty_25_75", int'(duty), 64);
    checkOutput("valids_25_75", valid_count - mark, 3);
    checkOutput("busy_len", last_busy_run, 40);

`ifndef PWM_DECODER_GLITCH_FILTER_EN
    // 99/1: round(99*255/100) = 252 ; 1/99: round(255/100) = 3
    applyStimulus(99, 1, 4);
    checkOutput("duty_99_1", int'(duty), 252);
    applyStimulus(1, 99, 4);
    checkOutput("duty_1_99", int'(duty), 3);
    checkOutput("stuck_1_99", int'(stuck), 0);
`endif

    // Stuck low.
    mark = valid_count;
    applyStimulus(0, 250, 1);
    checkOutput("duty_stuck_low", int'(duty), 0);
    checkOutput("stuck_low", int'(stuck), 1);
    checkOutput("valids_stuck_low", valid_count - mark, 1);

    // First edge clears stuck without an update; the following edge yields one.
    applyStimulus(25, 75, 1);
    checkOutput("duty_rearm", int'(duty), 0);
    checkOutput("stuck_rearm", int'(stuck), 0);
    applyStimulus(25, 75, 2);
    checkOutput("duty_relock", int'(duty), 64);

    // Stuck high: one result for the final 25/75 period plus one timeout.
    mark = valid_count;
    applyStimulus(500, 0, 1);
    checkOutput("duty_stuck_high", int'(duty), 255);
    checkOutput("stuck_high", int'(stuck), 1);
    checkOutput("valids_stuck_high", valid_count - mark, 2);

    // Reset in the middle of a divide.
    applyStimulus(0, 50, 1);
    applyStimulus(25, 75, 1);
    for (int i = 0; i < 20; i++) driveCycle(1'b1, 1'b1);
    checkOutput("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_duty", int'(duty), 0);
    checkOutput("abort_valid", int'(valid), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_stuck", int'(stuck), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    mark = valid_count;
    // Pin stays high through release: 6 high cycles in an 81-cycle period,
    // round(6*255/81) = 19.
    applyStimulus(5, 75, 1);
    checkOutput("valids_after_reset", valid_count - mark, 0);
    applyStimulus(25, 75, 1);
    checkOutput("valids_second_edge", valid_count - mark, 1);
    checkOutput("duty_after_reset", int'(duty), 19);

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    applyStimulus(25, 75, 4, 10);
    checkOutput("duty_glitch", int'(duty), 64);
`endif

    applyStimulus(0, 10, 1);
    checkOutput("double_valid", double_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
